// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with start/busy/done handshake.
// A start in IDLE captures load_value and counts it down to zero while
// enable is high. done pulses for one cycle on expiry. With AUTO_RELOAD
// set, the captured value is reloaded on expiry to give a periodic tick.
module countdown_timer #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_nxt;
    logic             done_nxt;

    // Next-state, next-count and expiry decode; abort outranks start/count.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = counter_out;
        reload_nxt = reload;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (abort) begin
                    cnt_nxt = '0;
                end else if (start) begin
                    if (load_value != '0) begin
                        cnt_nxt    = load_value;
                        reload_nxt = load_value;
                        state_nxt  = RUN;
                    end else begin
                        // A zero-length delay expires immediately.
                        cnt_nxt  = '0;
                        done_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (enable) begin
                    if (counter_out > WIDTH'(1)) begin
                        cnt_nxt = counter_out - WIDTH'(1);
                    end else begin
                        // Count of 1 is the last enabled cycle; the <= test
                        // also keeps a (never expected) 0 from wrapping.
                        done_nxt = 1'b1;
                        if (AUTO_RELOAD) begin
                            cnt_nxt = reload;
                        end else begin
                            cnt_nxt   = '0;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State, count, reload value and done pulse; reset clears all asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            counter_out <= '0;
            reload      <= '0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            counter_out <= cnt_nxt;
            reload      <= reload_nxt;
            done        <= done_nxt;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: table-driven vectors with a scoreboard queue, run
// against a one-shot instance and an auto-reload instance, plus sequences
// for asynchronous reset mid-count and a full-range count.
module tb_countdown_timer;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         en0, st0, ab0;
    logic [W-1:0] lv0, cnt0;
    logic         busy0, done0;
    logic         en1, st1, ab1;
    logic [W-1:0] lv1, cnt1;
    logic         busy1, done1;

    always #5 clock = ~clock;

    countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut0 (
        .clock(clock), .reset(reset), .enable(en0), .start(st0), .abort(ab0),
        .load_value(lv0), .counter_out(cnt0), .busy(busy0), .done(done0)
    );

    countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut1 (
        .clock(clock), .reset(reset), .enable(en1), .start(st1), .abort(ab1),
        .load_value(lv1), .counter_out(cnt1), .busy(busy1), .done(done1)
    );

    typedef struct {
        bit           sel;   // 0 = one-shot instance, 1 = auto-reload instance
        bit           st;
        bit           ab;
        bit           en;
        logic [W-1:0] lv;
        logic [W-1:0] ecnt;
        bit           ebusy;
        bit           edone;
    } vec_t;

    typedef struct {
        bit           sel;
        logic [W-1:0] ecnt;
        bit           ebusy;
        bit           edone;
        string        tag;
    } exp_t;

    vec_t tv[$];
    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic add(input bit sel, input bit st, input bit ab, input bit en,
                       input int lv, input int ecnt, input bit ebusy, input bit edone);
        vec_t v;
        v.sel = sel; v.st = st; v.ab = ab; v.en = en;
        v.lv = W'(lv); v.ecnt = W'(ecnt); v.ebusy = ebusy; v.edone = edone;
        tv.push_back(v);
    endtask

    // Drive one vector just after a falling edge, let the rising edge take it,
    // then compare the selected instance at the next falling edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        e.sel = v.sel; e.ecnt = v.ecnt; e.ebusy = v.ebusy; e.edone = v.edone; e.tag = tag;
        sbq.push_back(e);
        if (!v.sel) begin
            st0 = v.st; ab0 = v.ab; en0 = v.en; lv0 = v.lv;
            st1 = 1'b0; ab1 = 1'b0; en1 = 1'b0; lv1 = '0;
        end else begin
            st1 = v.st; ab1 = v.ab; en1 = v.en; lv1 = v.lv;
            st0 = 1'b0; ab0 = 1'b0; en0 = 1'b0; lv0 = '0;
        end
        @(posedge clock);
        @(negedge clock);
        e = sbq.pop_front();
        if (!e.sel) begin
            chk({e.tag, ".cnt"},  cnt0,         e.ecnt);
            chk({e.tag, ".busy"}, W'(busy0),    W'(e.ebusy));
            chk({e.tag, ".done"}, W'(done0),    W'(e.edone));
        end else begin
            chk({e.tag, ".cnt"},  cnt1,         e.ecnt);
            chk({e.tag, ".busy"}, W'(busy1),    W'(e.ebusy));
            chk({e.tag, ".done"}, W'(done1),    W'(e.edone));
        end
    endtask

    function automatic vec_t mk(input bit sel, input bit st, input bit ab, input bit en,
                                input int lv, input int ecnt, input bit ebusy, input bit edone);
        vec_t v;
        v.sel = sel; v.st = st; v.ab = ab; v.en = en;
        v.lv = W'(lv); v.ecnt = W'(ecnt); v.ebusy = ebusy; v.edone = edone;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        en0 = 1'b0; st0 = 1'b0; ab0 = 1'b0; lv0 = '0;
        en1 = 1'b0; st1 = 1'b0; ab1 = 1'b0; lv1 = '0;

        // Reset state, before any clock edge.
        #1;
        chk("rst.cnt0",  cnt0,      W'(0));
        chk("rst.busy0", W'(busy0), W'(0));
        chk("rst.done0", W'(done0), W'(0));
        chk("rst.cnt1",  cnt1,      W'(0));
        chk("rst.busy1", W'(busy1), W'(0));
        @(negedge clock);
        reset = 1'b1;

        //  sel st ab en lv  cnt busy done
        // One-shot count of 5.
        add(0, 1, 0, 1, 5,  5, 1, 0);
        add(0, 0, 0, 1, 0,  4, 1, 0);
        add(0, 0, 0, 1, 0,  3, 1, 0);
        add(0, 0, 0, 1, 0,  2, 1, 0);
        add(0, 0, 0, 1, 0,  1, 1, 0);
        add(0, 0, 0, 1, 0,  0, 0, 1);
        add(0, 0, 0, 1, 0,  0, 0, 0);
        // Enable low for three cycles at count 3.
        add(0, 1, 0, 1, 5,  5, 1, 0);
        add(0, 0, 0, 1, 0,  4, 1, 0);
        add(0, 0, 0, 1, 0,  3, 1, 0);
        add(0, 0, 0, 0, 0,  3, 1, 0);
        add(0, 0, 0, 0, 0,  3, 1, 0);
        add(0, 0, 0, 0, 0,  3, 1, 0);
        add(0, 0, 0, 1, 0,  2, 1, 0);
        add(0, 0, 0, 1, 0,  1, 1, 0);
        add(0, 0, 0, 1, 0,  0, 0, 1);
        add(0, 0, 0, 0, 0,  0, 0, 0);
        // Zero load: immediate done, never busy.
        add(0, 1, 0, 1, 0,  0, 0, 1);
        add(0, 0, 0, 1, 0,  0, 0, 0);
        // Expiry (start ignored in RUN) then a zero-load start: two done pulses.
        add(0, 1, 0, 1, 2,  2, 1, 0);
        add(0, 0, 0, 1, 0,  1, 1, 0);
        add(0, 1, 0, 1, 0,  0, 0, 1);
        add(0, 1, 0, 1, 0,  0, 0, 1);
        add(0, 0, 0, 1, 0,  0, 0, 0);
        // Abort at count 2: no done.
        add(0, 1, 0, 1, 4,  4, 1, 0);
        add(0, 0, 0, 1, 0,  3, 1, 0);
        add(0, 0, 0, 1, 0,  2, 1, 0);
        add(0, 0, 1, 1, 0,  0, 0, 0);
        add(0, 0, 0, 1, 0,  0, 0, 0);
        add(0, 0, 0, 1, 0,  0, 0, 0);
        // start and abort together in IDLE.
        add(0, 1, 1, 1, 7,  0, 0, 0);
        add(0, 0, 0, 1, 0,  0, 0, 0);
        // Restart attempt while busy is ignored.
        add(0, 1, 0, 1, 3,  3, 1, 0);
        add(0, 1, 0, 1, 9,  2, 1, 0);
        add(0, 0, 0, 1, 0,  1, 1, 0);
        add(0, 0, 0, 1, 0,  0, 0, 1);
        add(0, 0, 0, 1, 0,  0, 0, 0);
        // Auto-reload with load 3.
        add(1, 1, 0, 1, 3,  3, 1, 0);
        add(1, 0, 0, 1, 0,  2, 1, 0);
        add(1, 0, 0, 1, 0,  1, 1, 0);
        add(1, 0, 0, 1, 0,  3, 1, 1);
        add(1, 0, 0, 1, 0,  2, 1, 0);
        add(1, 0, 0, 1, 0,  1, 1, 0);
        add(1, 0, 0, 1, 0,  3, 1, 1);
        add(1, 1, 0, 1, 7,  2, 1, 0);
        add(1, 0, 0, 1, 0,  1, 1, 0);
        add(1, 0, 0, 1, 0,  3, 1, 1);
        add(1, 0, 0, 0, 0,  3, 1, 0);
        add(1, 0, 1, 1, 0,  0, 0, 0);
        add(1, 0, 0, 1, 0,  0, 0, 0);

        foreach (tv[i]) apply(tv[i], $sformatf("v%0d", i));

        // Full-range load counts all the way down without wrapping.
        apply(mk(0, 1, 0, 0, 15, 15, 1, 0), "max.load");
        for (int k = 14; k >= 1; k--)
            apply(mk(0, 0, 0, 1, 0, k, 1, 0), $sformatf("max.c%0d", k));
        apply(mk(0, 0, 0, 1, 0, 0, 0, 1), "max.exp");
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0), "max.idle");

        // Asynchronous reset mid-count at 3.
        apply(mk(0, 1, 0, 1, 5, 5, 1, 0), "ar.c5");
        apply(mk(0, 0, 0, 1, 0, 4, 1, 0), "ar.c4");
        apply(mk(0, 0, 0, 1, 0, 3, 1, 0), "ar.c3");
        #2;
        reset = 1'b0;
        #1;
        chk("ar.cnt",  cnt0,      W'(0));
        chk("ar.busy", W'(busy0), W'(0));
        chk("ar.done", W'(done0), W'(0));
        @(posedge clock);
        @(negedge clock);
        chk("ar.hold.cnt", cnt0, W'(0));
        reset = 1'b1;
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0), "ar.post1");
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0), "ar.post2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
